// File: rtl/message_validator_pkg.sv
// Shared constants and FSM state type for the decrypted-message validator.
package message_validator_pkg;

    localparam int         MSG_LENGTH = 32;
    localparam int         ADDR_WIDTH = 5;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_READ = 2'd1,
        ST_CHECK     = 2'd2,
        ST_DONE      = 2'd3
    } validator_state_t;

endpackage

// File: rtl/message_validator_if.sv
// Control, RAM read port and verdict bundle between the key-search controller and the validator.
interface message_validator_if #(
    parameter int ADDR_WIDTH = 5
) ();

    logic                  start;
    logic [7:0]            ram_read_data;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  finish;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] fail_address;

    modport master (
        output start,
        output ram_read_data,
        input  ram_address,
        input  finish,
        input  valid,
        input  fail_address
    );

    modport slave (
        input  start,
        input  ram_read_data,
        output ram_address,
        output finish,
        output valid,
        output fail_address
    );

endinterface

// File: rtl/message_validator_char_classifier.sv
// Purpose: flags a byte as legal plaintext (lowercase ASCII; space too under MSG_CHECK_SPACE_EN).
// Latency: purely combinational.
// Backpressure: none.
module char_classifier
    import message_validator_pkg::*;
#(
    parameter logic [7:0] LO = CHAR_LO,
    parameter logic [7:0] HI = CHAR_HI
) (
    input  logic [7:0] data,
    output logic       legal
);

    always_comb begin
        legal = (data >= LO) && (data <= HI);
`ifdef MSG_CHECK_SPACE_EN
        legal = legal || (data == CHAR_SPACE);
`else
        legal = legal && (data != CHAR_SPACE);
`endif
    end

endmodule

// File: rtl/message_validator.sv
// Purpose: scans MSG_LENGTH bytes of decrypted RAM, stops at first illegal byte (MSG_CHECK_SPACE_EN admits space).
// Latency: 2 cycles per byte; verdict after edge 2*MSG_LENGTH on pass, 2k+2 on failure at byte k.
// Backpressure: none; verdict held in DONE while start stays high, no re-trigger until start drops.
module message_validator
    import message_validator_pkg::*;
#(
    parameter int         MSG_LENGTH = message_validator_pkg::MSG_LENGTH,
    parameter int         ADDR_WIDTH = message_validator_pkg::ADDR_WIDTH,
    parameter logic [7:0] CHAR_LO    = message_validator_pkg::CHAR_LO,
    parameter logic [7:0] CHAR_HI    = message_validator_pkg::CHAR_HI
) (
    input  logic                clk,
    input  logic                reset,
    message_validator_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MSG_LENGTH - 1);

    validator_state_t      state, state_nxt;
    logic [ADDR_WIDTH-1:0] k, k_nxt;
    logic                  valid_r, valid_nxt;
    logic [ADDR_WIDTH-1:0] fail_r, fail_nxt;
    logic                  byte_legal;

    char_classifier #(
        .LO (CHAR_LO),
        .HI (CHAR_HI)
    ) u_classifier (
        .data  (bus.ram_read_data),
        .legal (byte_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            k       <= '0;
            valid_r <= 1'b0;
            fail_r  <= '0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            valid_r <= valid_nxt;
            fail_r  <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        valid_nxt = valid_r;
        fail_nxt  = fail_r;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    k_nxt     = '0;
                    valid_nxt = 1'b0;
                    fail_nxt  = '0;
                    state_nxt = ST_WAIT_READ;
                end
            end
            ST_WAIT_READ: state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!byte_legal) begin
                    valid_nxt = 1'b0;
                    fail_nxt  = k;
                    state_nxt = ST_DONE;
                end else if (k == LAST_IDX) begin
                    valid_nxt = 1'b1;
                    fail_nxt  = '0;
                    state_nxt = ST_DONE;
                end else begin
                    k_nxt     = k + 1'b1;
                    state_nxt = ST_WAIT_READ;
                end
            end
            ST_DONE: begin
                // Address returns to 0 on the way back to IDLE; verdict stays until the next start.
                if (!bus.start) begin
                    k_nxt     = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                k_nxt     = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_address  = k;
    assign bus.finish       = (state == ST_DONE);
    assign bus.valid        = valid_r;
    assign bus.fail_address = fail_r;

endmodule
